// File: rtl/instr_decode_ctrl.sv
// Instruction register plus multi-cycle control FSM for the register-file/ALU datapath.
// One instruction runs per s pulse; outputs are Moore (state + IR only).
module instr_decode_ctrl #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic          err,
  output logic [7:0]    imm8,
  output logic [4:0]    imm5,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_ALU    = 3'd4,
    ST_WR_REG = 3'd5,
    ST_WR_IMM = 3'd6
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] ir_reg;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  assign opcode = ir_reg[15:13];
  assign op     = ir_reg[12:11];
  assign rn     = ir_reg[10:8];
  assign rd     = ir_reg[7:5];
  assign sh     = ir_reg[4:3];
  assign rm     = ir_reg[2:0];
  assign imm8   = ir_reg[7:0];
  assign imm5   = ir_reg[4:0];

  // w is decoded from state, so IR only accepts new words while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg    <= '0;
      state_reg <= ST_WAIT;
    end else begin
      if (load && w) ir_reg <= in;
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    ALUop    = 2'b00;

    case (state_reg)
      ST_WAIT: begin
        w = 1'b1;
        if (s) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case ({opcode, op})
          5'b110_10:                     state_next = ST_WR_IMM;
          5'b110_00, 5'b101_11:          state_next = ST_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: state_next = ST_GET_A;
          default: begin
            err        = 1'b1;
            state_next = ST_WAIT;
          end
        endcase
      end
      ST_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = ST_GET_B;
      end
      ST_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        shift      = sh;
        state_next = ST_ALU;
      end
      ST_ALU: begin
        shift = sh;
        // MOV reg computes 0 + B; MVN is the only 101-class op without an A operand.
        if (opcode == 3'b110) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = op;
        end
        if (opcode == 3'b101 && op == 2'b01) begin
          loads      = 1'b1;
          state_next = ST_WAIT;
        end else begin
          loadc      = 1'b1;
          state_next = ST_WR_REG;
        end
      end
      ST_WR_REG: begin
        writenum   = rd;
        vsel       = 2'b00;
        write      = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WR_IMM: begin
        writenum   = rn;
        vsel       = 2'b10;
        write      = 1'b1;
        state_next = ST_WAIT;
      end
      default: state_next = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Randomized bench for instr_decode_ctrl: each instruction is expanded into its expected
// sequence of datapath phases by a reference model and compared cycle by cycle.
module tb_instr_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load, s;
  logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
  logic [7:0]  imm8;
  logic [4:0]  imm5;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;

  instr_decode_ctrl #(.IW(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
    .w(w), .err(err), .imm8(imm8), .imm5(imm5),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: instruction classes and the datapath phases each one walks through.
  typedef enum {K_ILL, K_MOVI, K_MOVR, K_MVN, K_ARITH, K_CMP} kind_t;
  typedef enum {P_DEC, P_RDA, P_RDB, P_EXE, P_WB, P_WIMM} phase_t;

  logic [15:0] ir_model;
  phase_t      plan_q[$];

  function automatic kind_t classify(input logic [15:0] i);
    if (i[15:13] == 3'b110 && i[12:11] == 2'b10) return K_MOVI;
    if (i[15:13] == 3'b110 && i[12:11] == 2'b00) return K_MOVR;
    if (i[15:13] == 3'b101 && i[12:11] == 2'b11) return K_MVN;
    if (i[15:13] == 3'b101 && i[12:11] == 2'b01) return K_CMP;
    if (i[15:13] == 3'b101)                      return K_ARITH;
    return K_ILL;
  endfunction

  task automatic build_plan(input logic [15:0] i);
    plan_q.delete();
    plan_q.push_back(P_DEC);
    case (classify(i))
      K_MOVI:  plan_q.push_back(P_WIMM);
      K_MOVR, K_MVN: begin
        plan_q.push_back(P_RDB); plan_q.push_back(P_EXE); plan_q.push_back(P_WB);
      end
      K_ARITH: begin
        plan_q.push_back(P_RDA); plan_q.push_back(P_RDB);
        plan_q.push_back(P_EXE); plan_q.push_back(P_WB);
      end
      K_CMP: begin
        plan_q.push_back(P_RDA); plan_q.push_back(P_RDB); plan_q.push_back(P_EXE);
      end
      default: ;
    endcase
  endtask

  // {w,err,readnum,writenum,write,loada,loadb,loadc,loads,asel,bsel,vsel,shift,ALUop}
  function automatic logic [20:0] pack(input logic ww, input logic ee, input logic [2:0] rn,
      input logic [2:0] wn, input logic [4:0] strobes, input logic as, input logic [1:0] vs,
      input logic [1:0] sh, input logic [1:0] op);
    return {ww, ee, rn, wn, strobes, as, 1'b0, vs, sh, op};
  endfunction

  localparam logic [20:0] IDLE_VEC = {1'b1, 20'd0};

  function automatic logic [20:0] expect_phase(input phase_t p, input logic [15:0] i);
    kind_t k = classify(i);
    logic [1:0] aop;
    case (p)
      P_DEC:  return pack(0, k == K_ILL, 0, 0, 5'b00000, 0, 0, 0, 0);
      P_RDA:  return pack(0, 0, i[10:8], 0, 5'b01000, 0, 0, 0, 0);
      P_RDB:  return pack(0, 0, i[2:0], 0, 5'b00100, 0, 0, i[4:3], 0);
      P_EXE: begin
        aop = (k == K_MOVR) ? 2'b00 : (k == K_MVN) ? 2'b11 : i[12:11];
        return pack(0, 0, 0, 0, (k == K_CMP) ? 5'b00001 : 5'b00010,
                    k == K_MOVR, 0, i[4:3], aop);
      end
      P_WB:   return pack(0, 0, 0, i[7:5], 5'b10000, 0, 2'b00, 0, 0);
      default: return pack(0, 0, 0, i[10:8], 5'b10000, 0, 2'b10, 0, 0);
    endcase
  endfunction

  logic [20:0] ctl_vec;
  assign ctl_vec = {w, err, readnum, writenum, write, loada, loadb, loadc, loads,
                    asel, bsel, vsel, shift, ALUop};

  task automatic check_cycle(input string tag, input logic [20:0] exp);
    check_eq({tag, ".ctl"}, 32'(ctl_vec), 32'(exp));
    check_eq({tag, ".imm8"}, 32'(imm8), 32'(ir_model[7:0]));
    check_eq({tag, ".imm5"}, 32'(imm5), 32'(ir_model[4:0]));
    check_eq({tag, ".onehot"}, 32'($countones({write, loada, loadb, loadc, loads}) > 1), 0);
  endtask

  // Called at a negedge while idle; leaves the bench at the negedge of the following WAIT cycle.
  task automatic run_instr(input logic [15:0] instr, input bit do_load);
    in = instr; load = do_load; s = 1'b1;
    if (do_load) ir_model = instr;
    build_plan(ir_model);
    foreach (plan_q[k]) begin
      @(negedge clk);
      check_cycle($sformatf("exec[%h].%0d", ir_model, k), expect_phase(plan_q[k], ir_model));
      in = 16'($urandom); load = 1'($urandom); s = 1'($urandom);
    end
    @(negedge clk);
    check_cycle($sformatf("done[%h]", ir_model), IDLE_VEC);
    $display("instr %h: %0d active cycles, returned to WAIT", ir_model, plan_q.size());
    load = 1'b0; s = 1'b0;
  endtask

  task automatic idle_load(input logic [15:0] word, input bit do_load);
    in = word; load = do_load; s = 1'b0;
    @(negedge clk);
    if (do_load) ir_model = word;
    check_cycle("idle", IDLE_VEC);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in = '0; load = 1'b0; s = 1'b0; ir_model = '0;
    @(negedge clk);
    check_cycle("reset", IDLE_VEC);
    reset = 1'b0;
    @(negedge clk);
    check_cycle("post_reset", IDLE_VEC);

    // Directed cases from the plan.
    idle_load(16'hD105, 1'b1);
    run_instr(16'hD105, 1'b0);
    run_instr(16'hD2FD, 1'b1);
    run_instr(16'hA162, 1'b1);
    run_instr(16'hA902, 1'b1);
    run_instr(16'h0000, 1'b1);
    run_instr(16'hC00B, 1'b1);
    run_instr(16'hB81A, 1'b1);
    run_instr(16'hB162, 1'b1);

    // Reset asserted during GET_B of an ADD.
    in = 16'hA162; load = 1'b1; s = 1'b1; ir_model = 16'hA162;
    build_plan(ir_model);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_cycle($sformatf("pre_rst.%0d", k), expect_phase(plan_q[k], ir_model));
      load = 1'b0; s = 1'b0;
    end
    reset = 1'b1;
    #1;
    ir_model = '0;
    check_cycle("mid_reset", IDLE_VEC);
    $display("reset during GET_B: outputs idle, IR cleared");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cycle("after_mid_reset", IDLE_VEC);

    // Random instructions biased toward the legal 101/110 classes.
    for (int n = 0; n < 200; n++) begin
      logic [15:0] word;
      word = 16'($urandom);
      if ($urandom_range(0, 3) != 0) word[15:14] = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      case ($urandom_range(0, 4))
        0: idle_load(word, 1'($urandom));
        1: run_instr(word, 1'b0);
        default: run_instr(word, 1'b1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
